// File: rtl/run_sequencer.sv
// run_sequencer: run controller and data-memory arbiter for the 9-bit
// accumulator core. Owns the core reset, runs a four-phase req/ack handshake
// with the host, counts RUN cycles, and hands the single data-memory port
// to the host (IDLE, FIN) or to the core (BOOT, RUN).
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> watchdog ends a run after TIMEOUT RUN cycles (timeout=1)
//   undefined -> no watchdog; RUN exits only on core_done, timeout stays 0,
//                and the cycle counter wraps modulo 2^CW.
module run_sequencer #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int CW       = 16,
    parameter int BOOT_CYC = 2,
    parameter int TIMEOUT  = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output logic          core_rst,
    input  logic          core_done,
    output logic          host_gnt,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic [DW-1:0] core_rdat,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Boot counter only needs to reach BOOT_CYC-1.
    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);

    // Illegal configurations elaborate this empty scope; it is the place a
    // reader finds the legal parameter ranges.
    if ((BOOT_CYC < 1) || (TIMEOUT < 1)) begin : g_bad_param_range
    end

    state_t          state_q, state_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic            timeout_q, timeout_d;
    logic            wd_hit_s;
    logic            host_owns_s;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    // The edge that completes RUN cycle number TIMEOUT is the watchdog exit.
    assign wd_hit_s = (cycles_q == WD_LAST);
`else
    // Without the watchdog the limit is never reached, so timeout_q stays 0.
    assign wd_hit_s = 1'b0;
`endif

    // Next-state logic: handshake sequencing, boot delay, cycle counting.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_BOOT;
                    boot_cnt_d = {BW{1'b0}};
                    cycles_d   = {CW{1'b0}};
                    timeout_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                // Every RUN edge counts, including the one that leaves RUN.
                cycles_d = cycles_q + {{(CW-1){1'b0}}, 1'b1};
                if (core_done) begin
                    // Completion beats a simultaneous watchdog hit.
                    state_d   = ST_FIN;
                    timeout_d = 1'b0;
                end else if (wd_hit_s) begin
                    state_d   = ST_FIN;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                boot_cnt_d = {BW{1'b0}};
                cycles_d   = {CW{1'b0}};
                timeout_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            boot_cnt_q <= {BW{1'b0}};
            cycles_q   <= {CW{1'b0}};
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
        end
    end

    // Moore outputs decoded from the registered state.
    assign host_owns_s = (state_q == ST_IDLE) || (state_q == ST_FIN);
    assign host_gnt    = host_owns_s;
    assign ack         = (state_q == ST_FIN);
    assign busy        = (state_q == ST_BOOT) || (state_q == ST_RUN);
    assign core_rst    = (state_q != ST_RUN);
    assign cycles      = cycles_q;
    assign timeout     = timeout_q;

    // Memory port mux: the non-owner's requests are simply not forwarded.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = {AW{1'b0}};
        mem_wdat = {DW{1'b0}};
        if (host_owns_s) begin
            mem_we   = host_we;
            mem_addr = host_addr;
            mem_wdat = host_wdat;
        end else begin
            mem_we   = core_we;
            mem_addr = core_addr;
            mem_wdat = core_wdat;
        end
    end

    // Both requesters see the memory's asynchronous read data directly.
    assign host_rdat = mem_rdat;
    assign core_rdat = mem_rdat;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer. A reference model computes each
// run's exit cycle, timeout flag and the expected memory image from the
// handshake rules; a simple array stands in for the data memory.
module tb_run_sequencer;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int CW     = 16;
    localparam int T_BOOT = 2;
    localparam int T_TO   = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          ack;
    logic          busy;
    logic          timeout;
    logic [CW-1:0] cycles;
    logic          core_rst;
    logic          core_done;
    logic          host_gnt;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdat;
    logic [DW-1:0] host_rdat;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdat;
    logic [DW-1:0] core_rdat;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    logic [DW-1:0] tb_mem  [256];
    logic [DW-1:0] ref_mem [256];

    int n_vec = 0;
    int n_err = 0;

    run_sequencer #(
        .AW(AW), .DW(DW), .CW(CW), .BOOT_CYC(T_BOOT), .TIMEOUT(T_TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy),
        .timeout(timeout), .cycles(cycles), .core_rst(core_rst),
        .core_done(core_done), .host_gnt(host_gnt), .host_we(host_we),
        .host_addr(host_addr), .host_wdat(host_wdat), .host_rdat(host_rdat),
        .core_we(core_we), .core_addr(core_addr), .core_wdat(core_wdat),
        .core_rdat(core_rdat), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdat;
    end
    assign mem_rdat = tb_mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_like(input string tag, input logic exp_ack,
                                 input int exp_cyc, input logic exp_to);
        chk({tag, ".ack"}, {31'd0, ack}, {31'd0, exp_ack});
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, ".host_gnt"}, {31'd0, host_gnt}, 32'd1);
        chk({tag, ".cycles"}, {16'd0, cycles}, exp_cyc[31:0]);
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    endtask

    task automatic host_read_chk(input string tag, input logic [7:0] a);
        host_we   = 1'b0;
        host_addr = a;
        #1;
        chk({tag, ".host_rdat"}, {24'd0, host_rdat}, {24'd0, ref_mem[a]});
        chk({tag, ".core_rdat"}, {24'd0, core_rdat}, {24'd0, ref_mem[a]});
    endtask

    // One complete run; the core signals done in RUN cycle done_at.
    task automatic do_run(input int done_at, input bit drop_req, input int hold_fin);
        int  exit_cyc;
        bit  to_exp;
        logic [7:0] a;
        exit_cyc = done_at;
        to_exp   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        if (done_at > T_TO) begin
            exit_cyc = T_TO;
            to_exp   = 1'b1;
        end
`endif
        host_we   = 1'b0;
        core_we   = 1'b0;
        core_done = 1'b1;          // must be ignored outside RUN
        req       = 1'b1;
        tick();                    // edge 0: request sampled
        host_we   = 1'b1;
        host_addr = 8'h10;
        host_wdat = 8'hFF;
        for (int k = 1; k <= T_BOOT; k++) begin
            #1;
            chk("boot.busy", {31'd0, busy}, 32'd1);
            chk("boot.core_rst", {31'd0, core_rst}, 32'd1);
            chk("boot.host_gnt", {31'd0, host_gnt}, 32'd0);
            chk("boot.mem_we", {31'd0, mem_we}, 32'd0);
            chk("boot.cycles", {16'd0, cycles}, 32'd0);
            tick();
        end
        for (int c = 1; c <= exit_cyc; c++) begin
            core_done = (c == done_at);
            core_we   = 1'($urandom_range(0, 1));
            core_addr = 8'($urandom_range(8'h80, 8'hFF));
            core_wdat = 8'($urandom);
            host_we   = 1'($urandom_range(0, 1));
            if (drop_req && c == 1) req = 1'b0;
            #1;
            chk("run.core_rst", {31'd0, core_rst}, 32'd0);
            chk("run.busy", {31'd0, busy}, 32'd1);
            chk("run.cycles", {16'd0, cycles}, c - 1);
            chk("run.mem_we", {31'd0, mem_we}, {31'd0, core_we});
            chk("run.mem_addr", {24'd0, mem_addr}, {24'd0, core_addr});
            if (core_we) ref_mem[core_addr] = core_wdat;
            tick();
        end
        core_done = 1'b0;
        core_we   = 1'b0;
        host_we   = 1'b0;
        chk_idle_like("fin", 1'b1, exit_cyc, to_exp);
        if (drop_req) begin
            tick();
            chk_idle_like("pulse", 1'b0, exit_cyc, to_exp);
        end else begin
            for (int h = 0; h < hold_fin; h++) begin
                tick();
                chk("fin.hold_ack", {31'd0, ack}, 32'd1);
            end
            req = 1'b0;
            tick();
            chk_idle_like("release", 1'b0, exit_cyc, to_exp);
        end
        host_read_chk("iso", 8'h10);
        a = 8'($urandom_range(8'h80, 8'hFF));
        host_read_chk("core_img", a);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        reset = 1'b1; req = 1'b0; core_done = 1'b0;
        host_we = 1'b0; host_addr = 8'h00; host_wdat = 8'h00;
        core_we = 1'b0; core_addr = 8'h00; core_wdat = 8'h00;

        // Reset
        tick();
        tick();
        chk_idle_like("reset", 1'b0, 0, 1'b0);
        reset = 1'b0;

        // Host load in IDLE
        host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'h5A;
        #1;
        chk("load.mem_we", {31'd0, mem_we}, 32'd1);
        chk("load.mem_addr", {24'd0, mem_addr}, 32'h10);
        chk("load.mem_wdat", {24'd0, mem_wdat}, 32'h5A);
        tick();
        ref_mem[8'h10] = 8'h5A;
        host_read_chk("load", 8'h10);

        // Random host loads outside 0x10
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(8'h20, 8'hFF));
            d = 8'($urandom);
            host_we = 1'b1; host_addr = a; host_wdat = d;
            tick();
            ref_mem[a] = d;
            host_read_chk("rload", a);
        end

        // Normal run, minimum-latency run, early req drop
        do_run(20, 1'b0, 2);
        do_run(1, 1'b0, 0);
        do_run($urandom_range(2, 30), 1'b1, 0);

`ifdef SEQ_TIMEOUT_EN
        do_run(T_TO + 7, 1'b0, 1);   // watchdog
        do_run(T_TO, 1'b0, 0);       // done and limit together
`else
        do_run(205, 1'b0, 0);        // no watchdog: still busy past 200
`endif

        // Random runs
        for (int i = 0; i < 4; i++) begin
            do_run($urandom_range(1, 60), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in RUN cycle 5
        req = 1'b1;
        tick();
        for (int k = 0; k < T_BOOT + 4; k++) tick();
        chk("mid.cycles", {16'd0, cycles}, 32'd4);
        chk("mid.core_rst", {31'd0, core_rst}, 32'd0);
        reset = 1'b1;
        req   = 1'b0;
        tick();
        reset = 1'b0;
        chk_idle_like("midrst", 1'b0, 0, 1'b0);
        do_run($urandom_range(3, 25), 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run controller and data-memory arbiter for the 9-bit accumulator core. It sits between a host/testbench port and the core, and owns the core's reset. It also multiplexes the single data-memory port: the host has it while the core is idle, and the core has it while a run is in progress. It runs a four-phase req/ack handshake, counts execution cycles, and optionally aborts runaway programs with a watchdog.

## Interface
Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory data width
- CW, 16, cycle-counter width
- BOOT_CYC, 2, cycles core_rst is held after a run starts (≥1)
- TIMEOUT, 1000, watchdog limit in RUN cycles (1 ≤ TIMEOUT ≤ 2^CW−1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req  in  1  host run request (level, four-phase)
- ack  out  1  run finished; held until req falls
- busy  out  1  high in BOOT and RUN
- timeout  out  1  last run ended by the watchdog
- cycles  out  CW  RUN cycles of the last or current run
- core_rst  out  1  reset to the core
- core_done  in  1  core completion flag (combinational from the core)
- host_gnt  out  1  host owns memory (IDLE, FIN)
- host_we  in  1  host write enable
- host_addr  in  AW  host address
- host_wdat  in  DW  host write data
- host_rdat  out  DW  host read data (= mem_rdat)
- core_we  in  1  core store enable
- core_addr  in  AW  core address
- core_wdat  in  DW  core store data
- core_rdat  out  DW  core load data (= mem_rdat)
- mem_we  out  1  to data memory
- mem_addr  out  AW  to data memory
- mem_wdat  out  DW  to data memory
- mem_rdat  in  DW  from data memory (asynchronous read)

## Operation
- States: IDLE, BOOT, RUN, FIN.
- IDLE:
  - core_rst=1, host_gnt=1.
  - req=1 → BOOT.
  - On the IDLE→BOOT edge: cycles←0, timeout←0, boot counter←0.
- BOOT:
  - core_rst=1, host_gnt=0, busy=1.
  - Stays BOOT_CYC cycles, then → RUN.
- RUN:
  - core_rst=0, busy=1; memory is muxed to the core.
  - cycles increments on every RUN edge, including the exit edge.
  - core_done=1 → FIN with timeout←0.
  - Else if cycles==TIMEOUT−1 → FIN with timeout←1.
- FIN:
  - core_rst=1, ack=1, host_gnt=1; cycles and timeout are frozen.
  - req=0 → IDLE.
- Memory mux:
  - Host owns the port in IDLE and FIN; core owns it in BOOT and RUN.
  - mem_we = owner's we; the non-owner's writes are dropped, never queued.
  - Both read-data outputs always carry mem_rdat.
- Boundary cases:
  - req falling during BOOT or RUN is ignored; the run completes. FIN is then left on the next edge, so ack is a one-cycle pulse.
  - core_done and the watchdog limit in the same cycle: done wins, timeout=0.
  - core_done seen outside RUN is ignored.
  - host_we during BOOT or RUN never reaches memory.
  - reset in any state: next edge → IDLE, with core_rst=1, ack=0, busy=0, timeout=0, cycles=0, boot counter 0.

## Timing
- Reset values: core_rst=1, host_gnt=1, ack=0, busy=0, timeout=0, cycles=0; state IDLE.
- All control outputs decode from registered state (Moore outputs).
- The mem_* mux is combinational from state and the selected requester, with zero added latency.
- Start latency:
  - req sampled high at edge 0 → BOOT after edge 0.
  - core_rst falls after edge BOOT_CYC.
  - The first RUN cycle has the core's PC at 0.
- A run of N RUN cycles (core_done sampled in the Nth) gives cycles=N and ack high after the exit edge.
- ack falls one edge after req is sampled low.
- Minimum req-to-ack latency is BOOT_CYC+1 edges.

## Configuration
- SEQ_TIMEOUT_EN defined: watchdog active as described.
- SEQ_TIMEOUT_EN undefined:
  - No watchdog compare; RUN exits only on core_done.
  - timeout is tied to 0.
  - cycles wraps modulo 2^CW.

## Test plan
- Reset: assert reset for 2 cycles → core_rst=1, host_gnt=1, ack=0, busy=0, cycles=0.
- Host load in IDLE: host_we=1, addr 0x10, data 0x5A → mem_we=1 that cycle; reading addr 0x10 afterwards gives host_rdat=0x5A.
- Normal run: req=1, core_done asserted in RUN cycle 20 → core_rst low for exactly 20 cycles, ack=1, cycles=20, timeout=0. Drop req → ack=0 next edge, state IDLE.
- Watchdog (TIMEOUT=50, macro defined): core_done held 0 → FIN after 50 RUN cycles, cycles=50, timeout=1. Same core_done 0 plus macro undefined → still busy after 200 cycles.
- Isolation: host_we=1 to addr 0x10 with data 0xFF during RUN, core_we=0 → mem_we=0 and addr 0x10 still reads 0x5A after FIN.
- Reset mid-run: reset in RUN cycle 5 → IDLE next edge, core_rst=1, cycles=0. A fresh req then completes normally.
